// File: rtl/cam_i2c_responder.sv
// I2C/SCCB register-port target for the camera configuration master.
// Oversamples SCL/SDA on clk; supports register writes, pointer set and burst reads.
module cam_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR = 7'h21,
  parameter int unsigned REG_AW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_scl,
  input  logic              i2c_sda_in,
  output logic              i2c_sda_pull,
  output logic              wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int unsigned Depth = 2 ** REG_AW;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StReg,
    StRegAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck
  } state_e;

  logic [2:0]        r_scl_sync, r_sda_sync;
  state_e            r_state, w_state_d;
  logic [3:0]        r_cnt, w_cnt_d;
  logic [7:0]        r_shift, w_shift_d;
  logic              r_rw, w_rw_d;
  logic              r_acked, w_acked_d;
  logic              r_pull, w_pull_d;
  logic              r_busy, w_busy_d;
  logic [REG_AW-1:0] r_ptr, w_ptr_d;
  logic              r_strobe, w_strobe_d;
  logic [REG_AW-1:0] r_wr_addr, w_wr_addr_d;
  logic [7:0]        r_wr_data, w_wr_data_d;
  logic              w_we;
  logic [7:0]        r_regs [Depth];

  logic       w_scl_rise, w_scl_fall, w_scl_high;
  logic       w_sda_rise, w_sda_fall, w_sda;
  logic       w_start, w_stop;
  logic [7:0] w_byte, w_rd_byte;

  // Index [1] is the synchronized level, [2] the previous sample for edge detection.
  assign w_scl_rise = r_scl_sync[1] & ~r_scl_sync[2];
  assign w_scl_fall = ~r_scl_sync[1] & r_scl_sync[2];
  assign w_scl_high = r_scl_sync[1] & r_scl_sync[2];
  assign w_sda_rise = r_sda_sync[1] & ~r_sda_sync[2];
  assign w_sda_fall = ~r_sda_sync[1] & r_sda_sync[2];
  assign w_sda      = r_sda_sync[1];
  assign w_start    = w_sda_fall & w_scl_high;
  assign w_stop     = w_sda_rise & w_scl_high;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_rd_byte  = r_regs[r_ptr];

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_shift_d   = r_shift;
    w_rw_d      = r_rw;
    w_acked_d   = r_acked;
    w_pull_d    = r_pull;
    w_busy_d    = r_busy;
    w_ptr_d     = r_ptr;
    w_strobe_d  = 1'b0;
    w_wr_addr_d = r_wr_addr;
    w_wr_data_d = r_wr_data;
    w_we        = 1'b0;
    if (w_start) begin
      w_state_d = StAddr;
      w_cnt_d   = 4'd0;
      w_acked_d = 1'b0;
      w_pull_d  = 1'b0;
    end else if (w_stop) begin
      w_state_d = StIdle;
      w_pull_d  = 1'b0;
      w_busy_d  = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: ;
        StAddr, StReg, StWdata: begin
          if (w_scl_rise) begin
            w_shift_d = w_byte;
            w_cnt_d   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_d = 4'd0;
              if (r_state == StAddr) begin
                if (w_byte[7:1] == DEV_ADDR) begin
                  w_state_d = StAddrAck;
                  w_rw_d    = w_byte[0];
                end else begin
                  w_state_d = StIdle;
                  w_busy_d  = 1'b0;
                end
              end else if (r_state == StReg) begin
                w_ptr_d   = w_byte[REG_AW-1:0];
                w_state_d = StRegAck;
              end else begin
                w_we        = 1'b1;
                w_strobe_d  = 1'b1;
                w_wr_addr_d = r_ptr;
                w_wr_data_d = w_byte;
                w_ptr_d     = r_ptr + 1'b1;
                w_state_d   = StWdataAck;
              end
            end
          end
        end
        StAddrAck, StRegAck, StWdataAck: begin
          // First fall drives the ACK, second fall hands SDA to the next byte.
          if (w_scl_fall) begin
            if (!r_acked) begin
              w_pull_d  = 1'b1;
              w_acked_d = 1'b1;
              if (r_state == StAddrAck) w_busy_d = 1'b1;
            end else begin
              w_acked_d = 1'b0;
              w_cnt_d   = 4'd0;
              w_pull_d  = 1'b0;
              if (r_state == StAddrAck && r_rw) begin
                w_state_d = StRdata;
                w_shift_d = w_rd_byte;
                w_pull_d  = ~w_rd_byte[7];
              end else if (r_state == StAddrAck) begin
                w_state_d = StReg;
              end else begin
                w_state_d = StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (w_scl_rise) begin
            w_cnt_d = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_pull_d  = 1'b0;
              w_acked_d = 1'b0;
              w_state_d = StRdataAck;
            end else begin
              w_pull_d  = ~r_shift[6];
              w_shift_d = {r_shift[6:0], 1'b0};
            end
          end
        end
        StRdataAck: begin
          if (w_scl_rise && !r_acked) begin
            w_ptr_d = r_ptr + 1'b1;
            if (!w_sda) begin
              w_acked_d = 1'b1;
            end else begin
              w_state_d = StIdle;
              w_busy_d  = 1'b0;
            end
          end else if (w_scl_fall && r_acked) begin
            w_acked_d = 1'b0;
            w_cnt_d   = 4'd0;
            w_shift_d = w_rd_byte;
            w_pull_d  = ~w_rd_byte[7];
            w_state_d = StRdata;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= 3'b111;
      r_sda_sync <= 3'b111;
      r_state    <= StIdle;
      r_cnt      <= 4'd0;
      r_shift    <= 8'h00;
      r_rw       <= 1'b0;
      r_acked    <= 1'b0;
      r_pull     <= 1'b0;
      r_busy     <= 1'b0;
      r_ptr      <= '0;
      r_strobe   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
      for (int unsigned i = 0; i < Depth; i++) r_regs[i] <= 8'h00;
    end else begin
      r_scl_sync <= {r_scl_sync[1:0], i2c_scl};
      r_sda_sync <= {r_sda_sync[1:0], i2c_sda_in};
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_shift    <= w_shift_d;
      r_rw       <= w_rw_d;
      r_acked    <= w_acked_d;
      r_pull     <= w_pull_d;
      r_busy     <= w_busy_d;
      r_ptr      <= w_ptr_d;
      r_strobe   <= w_strobe_d;
      r_wr_addr  <= w_wr_addr_d;
      r_wr_data  <= w_wr_data_d;
      if (w_we) r_regs[r_ptr] <= w_byte;
    end
  end

  // Gating with reset frees the bus in the very cycle reset is raised.
  assign i2c_sda_pull = r_pull & ~reset;
  assign wr_strobe    = r_strobe;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign busy         = r_busy;

endmodule
